vm_credit: RTL and testbench

//  Parametrised vending controller: accumulates credit from a 3-denomination coin

---
 rtl/vm_credit.sv | 113 +++++++++++
 tb/tb_vm_credit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vm_credit.sv
// Vending credit controller: accumulates coin value, vends at PRICE and
// refunds overpayment or cancelled credit one change coin per cycle.
module vm_credit #(
    parameter int PRICE    = 15,
    parameter int VAL1     = 5,
    parameter int VAL2     = 10,
    parameter int VAL3     = 25,
    parameter int CHG_UNIT = 5,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    coin,
    input  logic          cancel,
    output logic          coin_ready,
    output logic          coin_reject,
    output logic          vend,
    output logic          chg_pulse,
    output logic [CW-1:0] credit,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CW:0]   PRICE_W  = (CW+1)'(PRICE);
    localparam logic [CW:0]   V1_W     = (CW+1)'(VAL1);
    localparam logic [CW:0]   V2_W     = (CW+1)'(VAL2);
    localparam logic [CW:0]   V3_W     = (CW+1)'(VAL3);
    localparam logic [CW:0]   CRED_MAX = {1'b0, {CW{1'b1}}};
    localparam logic [CW-1:0] UNIT_W   = CW'(CHG_UNIT);

    state_t        state, state_n;
    logic [CW-1:0] credit_n;
    logic          vend_n, chg_n, rej_n;
    logic [CW:0]   coin_val;
    logic [CW:0]   sum;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = V1_W;
            2'b10:   coin_val = V2_W;
            2'b11:   coin_val = V3_W;
            default: coin_val = '0;
        endcase
    end

    // One extra bit so an overflowing coin is detected instead of wrapping.
    assign sum = {1'b0, credit} + coin_val;

    assign coin_ready = (state == IDLE) || (state == COLLECT);
    assign busy       = (state == VEND) || (state == CHANGE);

    always_comb begin
        state_n  = state;
        credit_n = credit;
        vend_n   = 1'b0;
        chg_n    = 1'b0;
        rej_n    = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (cancel && state == COLLECT) begin
                    state_n = CHANGE;
                    rej_n   = (coin != 2'b00);
                end else if (coin != 2'b00) begin
                    if (sum > CRED_MAX) begin
                        rej_n = 1'b1;
                    end else if (sum >= PRICE_W) begin
                        state_n  = VEND;
                        credit_n = CW'(sum - PRICE_W);
                        vend_n   = 1'b1;
                    end else begin
                        state_n  = COLLECT;
                        credit_n = sum[CW-1:0];
                    end
                end
            end
            VEND: begin
                rej_n   = (coin != 2'b00);
                state_n = (credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                rej_n = (coin != 2'b00);
                chg_n = 1'b1;
                // A residue below one change coin still costs a full coin.
                if (credit <= UNIT_W) begin
                    credit_n = '0;
                    state_n  = IDLE;
                end else begin
                    credit_n = credit - UNIT_W;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            vend        <= 1'b0;
            chg_pulse   <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            vend        <= vend_n;
            chg_pulse   <= chg_n;
            coin_reject <= rej_n;
        end
    end

endmodule

// File: tb/tb_vm_credit.sv
// Bench for vm_credit: directed scenarios plus random coins/cancels against
// a transaction-level model that schedules vend/refund outputs in a queue.
module tb_vm_credit;

    localparam int PRICE = 15;
    localparam int UNIT  = 5;
    localparam int MAXC  = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic       coin_ready, coin_reject, vend, chg_pulse, busy;
    logic [7:0] credit;

    logic [1:0] coin5 = 2'b00;
    logic       cancel5 = 1'b0;
    logic       ready5, reject5, vend5, chg5, busy5;
    logic [4:0] credit5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vm_credit dut (
        .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel),
        .coin_ready(coin_ready), .coin_reject(coin_reject), .vend(vend),
        .chg_pulse(chg_pulse), .credit(credit), .busy(busy)
    );

    vm_credit #(.CW(5), .PRICE(30)) dut5 (
        .clk(clk), .rst_n(rst_n), .coin(coin5), .cancel(cancel5),
        .coin_ready(ready5), .coin_reject(reject5), .vend(vend5),
        .chg_pulse(chg5), .credit(credit5), .busy(busy5)
    );

    typedef struct {
        bit v;
        bit c;
        int cr;
        bit b;
    } ent_t;

    ent_t q[$];
    int   m_credit = 0;
    bit   e_vend = 0, e_chg = 0, e_rej = 0, e_busy = 0;

    function automatic int coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    // Refund of cr: ceil(cr/UNIT) consecutive coins, last one ends busy.
    task automatic sched_refund(input int cr);
        int k;
        ent_t e;
        k = (cr + UNIT - 1) / UNIT;
        for (int i = 1; i <= k; i++) begin
            e.v  = 1'b0;
            e.c  = 1'b1;
            e.cr = (cr - i * UNIT > 0) ? cr - i * UNIT : 0;
            e.b  = (i < k);
            q.push_back(e);
        end
    endtask

    task automatic model_edge(input logic [1:0] c, input logic can);
        ent_t e;
        int   s;
        e_rej  = 1'b0;
        e_vend = 1'b0;
        e_chg  = 1'b0;
        if (q.size() > 0) begin
            e        = q.pop_front();
            e_vend   = e.v;
            e_chg    = e.c;
            m_credit = e.cr;
            e_busy   = e.b;
            e_rej    = (c != 2'b00);
        end else begin
            e_busy = 1'b0;
            if (can && m_credit > 0) begin
                e_rej  = (c != 2'b00);
                e_busy = 1'b1;
                sched_refund(m_credit);
            end else if (c != 2'b00) begin
                s = m_credit + coin_value(c);
                if (s > MAXC) begin
                    e_rej = 1'b1;
                end else if (s >= PRICE) begin
                    m_credit = s - PRICE;
                    e_vend   = 1'b1;
                    e_busy   = 1'b1;
                    e.v  = 1'b0;
                    e.c  = 1'b0;
                    e.cr = m_credit;
                    e.b  = (m_credit > 0);
                    q.push_back(e);
                    if (m_credit > 0) sched_refund(m_credit);
                end else begin
                    m_credit = s;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("credit", 32'(credit), 32'(m_credit));
        chk("vend", 32'(vend), 32'(e_vend));
        chk("chg_pulse", 32'(chg_pulse), 32'(e_chg));
        chk("coin_reject", 32'(coin_reject), 32'(e_rej));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("coin_ready", 32'(coin_ready), 32'(!e_busy));
    endtask

    task automatic step(input logic [1:0] c, input logic can);
        coin   = c;
        cancel = can;
        @(posedge clk);
        model_edge(c, can);
        #1;
        check_all();
    endtask

    initial begin
        // Reset defaults
        #12;
        check_all();
        chk("rst5_credit", 32'(credit5), 32'd0);
        chk("rst5_ready", 32'(ready5), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 5 + 10 -> exact vend, no change
        step(2'b01, 1'b0);
        step(2'b10, 1'b0);
        chk("t1_vend", 32'(vend), 32'd1);
        chk("t1_credit", 32'(credit), 32'd0);
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);

        // 25 -> vend, then change 10->5->0 with coins offered while busy
        step(2'b11, 1'b0);
        chk("t2_credit_vend", 32'(credit), 32'd10);
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        chk("t2_first_chg", 32'(chg_pulse), 32'd1);
        chk("t2_credit_5", 32'(credit), 32'd5);
        step(2'b10, 1'b0);
        chk("t4_reject", 32'(coin_reject), 32'd1);
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);

        // 5 then cancel -> one change coin
        step(2'b01, 1'b0);
        step(2'b10, 1'b1);
        chk("t3_cancel_rej", 32'(coin_reject), 32'd1);
        step(2'b00, 1'b0);
        chk("t3_chg", 32'(chg_pulse), 32'd1);
        chk("t3_credit", 32'(credit), 32'd0);
        step(2'b00, 1'b0);

        // Cancel in IDLE is ignored and the coin accepted
        step(2'b01, 1'b1);
        chk("idle_cancel_credit", 32'(credit), 32'd5);
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);

        // Narrow instance: overflow rejection at CW=5, PRICE=30
        coin5 = 2'b11;
        step(2'b00, 1'b0);
        chk("t5_credit25", 32'(credit5), 32'd25);
        coin5 = 2'b10;
        step(2'b00, 1'b0);
        chk("t5_reject", 32'(reject5), 32'd1);
        chk("t5_credit_kept", 32'(credit5), 32'd25);
        chk("t5_ready", 32'(ready5), 32'd1);
        coin5 = 2'b01;
        step(2'b00, 1'b0);
        chk("t5_vend", 32'(vend5), 32'd1);
        chk("t5_credit0", 32'(credit5), 32'd0);
        chk("t5_no_reject", 32'(reject5), 32'd0);
        coin5 = 2'b00;
        step(2'b00, 1'b0);
        chk("t5_vend_done", 32'(vend5), 32'd0);
        chk("t5_idle", 32'(busy5), 32'd0);

        // Asynchronous reset in the middle of a refund
        step(2'b11, 1'b0);
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_chg", 32'(chg_pulse), 32'd0);
        chk("t6_credit", 32'(credit), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(coin_ready), 32'd1);
        q.delete();
        m_credit = 0;
        e_vend = 0; e_chg = 0; e_rej = 0; e_busy = 0;
        #2;
        rst_n = 1'b1;
        step(2'b00, 1'b0);

        // Random coins and occasional cancels
        for (int n = 0; n < 400; n++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        for (int n = 0; n < 8; n++) step(2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
